// File: rtl/vc_input_buffer.sv
// Per-port virtual-channel input buffer: two independent FWFT FIFOs, one per VC,
// each with a packet-ownership state machine that reports free/owner info back to the VC allocator.

module vc_input_buffer_lane #(
    parameter int bit_of_flit    = 32,
    parameter int bit_of_address = 4,
    parameter int fifo_depth     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [bit_of_flit-1:0]    flit_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [bit_of_flit-1:0]    flit_out,
    output logic                      valid,
    output logic                      vc_free,
    output logic [bit_of_address-1:0] src_addr,
    output logic                      overflow_hit,
    output logic                      protocol_hit
);

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(fifo_depth);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [bit_of_flit-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [bit_of_flit-1:0] head_flit;
    logic [bit_of_flit-1:0] last_out;
    logic [1:0]             wr_type;
    logic                   type_ok;
    logic                   pop;
    logic                   has_room;
    logic                   accept;

    assign wr_type   = flit_in[bit_of_flit-1 -: 2];
    assign head_flit = mem[rd_ptr];
    assign pop       = rd_en && (count != '0);
    assign has_room  = (count < DEPTH) || pop;

    // Legality depends only on the VC state; capacity is checked afterwards.
    always_comb begin
        type_ok = 1'b0;
        case (state)
            IDLE:    type_ok = wr_type[1];
            ACTIVE:  type_ok = ~wr_type[1];
            default: type_ok = 1'b0;
        endcase
    end

    assign accept       = wr_en && type_ok && has_room;
    assign overflow_hit = wr_en && type_ok && !has_room;
    assign protocol_hit = wr_en && !type_ok;

    // A VC is released only when its tail (01 or 11, i.e. type bit 0 set) leaves the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (wr_type == 2'b11) ? DRAIN : ACTIVE;
            end
            ACTIVE: begin
                if (accept && (wr_type == 2'b01)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && head_flit[bit_of_flit-2]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_addr <= '0;
        end else begin
            state <= state_next;
            if (accept && (state == IDLE))
                src_addr <= flit_in[bit_of_flit-3 -: bit_of_address];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= flit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_out <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                last_out <= head_flit;
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Once empty, the output keeps showing the most recently popped flit.
    assign flit_out = (count != '0) ? head_flit : last_out;
    assign valid    = (count != '0);
    assign vc_free  = (state == IDLE);

endmodule

module vc_input_buffer #(
    parameter int bit_of_flit    = 32,
    parameter int bit_of_address = 4,
    parameter int fifo_depth     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [bit_of_flit-1:0]    flit_in_vc0,
    input  logic                      wr_en_vc0,
    input  logic [bit_of_flit-1:0]    flit_in_vc1,
    input  logic                      wr_en_vc1,
    input  logic                      rd_en_vc0,
    input  logic                      rd_en_vc1,
    output logic [bit_of_flit-1:0]    flit_out_vc0,
    output logic [bit_of_flit-1:0]    flit_out_vc1,
    output logic                      valid_vc0,
    output logic                      valid_vc1,
    output logic                      vc_free0,
    output logic                      vc_free1,
    output logic [bit_of_address-1:0] src_addr_vc0,
    output logic [bit_of_address-1:0] src_addr_vc1,
    output logic                      overflow,
    output logic                      protocol_err
);

    logic overflow_hit0;
    logic overflow_hit1;
    logic protocol_hit0;
    logic protocol_hit1;

    vc_input_buffer_lane #(
        .bit_of_flit   (bit_of_flit),
        .bit_of_address(bit_of_address),
        .fifo_depth    (fifo_depth)
    ) u_lane0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_in     (flit_in_vc0),
        .wr_en       (wr_en_vc0),
        .rd_en       (rd_en_vc0),
        .flit_out    (flit_out_vc0),
        .valid       (valid_vc0),
        .vc_free     (vc_free0),
        .src_addr    (src_addr_vc0),
        .overflow_hit(overflow_hit0),
        .protocol_hit(protocol_hit0)
    );

    vc_input_buffer_lane #(
        .bit_of_flit   (bit_of_flit),
        .bit_of_address(bit_of_address),
        .fifo_depth    (fifo_depth)
    ) u_lane1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_in     (flit_in_vc1),
        .wr_en       (wr_en_vc1),
        .rd_en       (rd_en_vc1),
        .flit_out    (flit_out_vc1),
        .valid       (valid_vc1),
        .vc_free     (vc_free1),
        .src_addr    (src_addr_vc1),
        .overflow_hit(overflow_hit1),
        .protocol_hit(protocol_hit1)
    );

    // Error flags are sticky until reset so firmware can poll them at leisure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (overflow_hit0 || overflow_hit1) overflow <= 1'b1;
            if (protocol_hit0 || protocol_hit1) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed testbench for vc_input_buffer: packet ownership, FWFT ordering,
// overflow and protocol-error flags, and asynchronous reset mid-packet.

module tb_vc_input_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] flit_in_vc0;
    logic        wr_en_vc0;
    logic [31:0] flit_in_vc1;
    logic        wr_en_vc1;
    logic        rd_en_vc0;
    logic        rd_en_vc1;
    logic [31:0] flit_out_vc0;
    logic [31:0] flit_out_vc1;
    logic        valid_vc0;
    logic        valid_vc1;
    logic        vc_free0;
    logic        vc_free1;
    logic [3:0]  src_addr_vc0;
    logic [3:0]  src_addr_vc1;
    logic        overflow;
    logic        protocol_err;

    int compareCount;
    int failCount;

    vc_input_buffer #(
        .bit_of_flit   (32),
        .bit_of_address(4),
        .fifo_depth    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_in_vc0 (flit_in_vc0),
        .wr_en_vc0   (wr_en_vc0),
        .flit_in_vc1 (flit_in_vc1),
        .wr_en_vc1   (wr_en_vc1),
        .rd_en_vc0   (rd_en_vc0),
        .rd_en_vc1   (rd_en_vc1),
        .flit_out_vc0(flit_out_vc0),
        .flit_out_vc1(flit_out_vc1),
        .valid_vc0   (valid_vc0),
        .valid_vc1   (valid_vc1),
        .vc_free0    (vc_free0),
        .vc_free1    (vc_free1),
        .src_addr_vc0(src_addr_vc0),
        .src_addr_vc1(src_addr_vc1),
        .overflow    (overflow),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; inputs return to idle 1ns after the edge, where outputs are sampled.
    task automatic applyStimulus(input logic [31:0] f0, input logic w0, input logic r0,
                                 input logic [31:0] f1, input logic w1, input logic r1);
        flit_in_vc0 = f0;
        wr_en_vc0   = w0;
        rd_en_vc0   = r0;
        flit_in_vc1 = f1;
        wr_en_vc1   = w1;
        rd_en_vc1   = r1;
        @(posedge clk);
        #1;
        flit_in_vc0 = '0;
        wr_en_vc0   = 1'b0;
        rd_en_vc0   = 1'b0;
        flit_in_vc1 = '0;
        wr_en_vc1   = 1'b0;
        rd_en_vc1   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst_n        = 1'b0;
        flit_in_vc0  = '0;
        wr_en_vc0    = 1'b0;
        rd_en_vc0    = 1'b0;
        flit_in_vc1  = '0;
        wr_en_vc1    = 1'b0;
        rd_en_vc1    = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_vc_free0", 32'(vc_free0), 32'd1);
        checkOutput("rst_vc_free1", 32'(vc_free1), 32'd1);
        checkOutput("rst_valid0", 32'(valid_vc0), 32'd0);
        checkOutput("rst_valid1", 32'(valid_vc1), 32'd0);
        checkOutput("rst_flit_out0", flit_out_vc0, 32'h0);
        checkOutput("rst_flit_out1", flit_out_vc1, 32'h0);
        checkOutput("rst_src0", 32'(src_addr_vc0), 32'h0);
        checkOutput("rst_src1", 32'(src_addr_vc1), 32'h0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_protocol", 32'(protocol_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] three-flit packet on VC0");

        applyStimulus(32'h8C000001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("hdr_vc_free0", 32'(vc_free0), 32'd0);
        checkOutput("hdr_src0", 32'(src_addr_vc0), 32'h3);
        checkOutput("hdr_valid0", 32'(valid_vc0), 32'd1);
        checkOutput("hdr_fwft0", flit_out_vc0, 32'h8C000001);
        applyStimulus(32'h0C000002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h4C000003, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pkt_head0", flit_out_vc0, 32'h8C000001);
        checkOutput("pkt_valid0", 32'(valid_vc0), 32'd1);
        checkOutput("pkt_vc1_free", 32'(vc_free1), 32'd1);

        $display("[TB] draining VC0");
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("pop1_flit0", flit_out_vc0, 32'h0C000002);
        checkOutput("pop1_free0", 32'(vc_free0), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("pop2_flit0", flit_out_vc0, 32'h4C000003);
        checkOutput("pop2_free0", 32'(vc_free0), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("pop3_free0", 32'(vc_free0), 32'd1);
        checkOutput("pop3_valid0", 32'(valid_vc0), 32'd0);
        checkOutput("pop3_hold0", flit_out_vc0, 32'h4C000003);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("empty_pop_valid0", 32'(valid_vc0), 32'd0);
        checkOutput("empty_pop_protocol", 32'(protocol_err), 32'd0);

        $display("[TB] single-flit packet on VC1");
        applyStimulus(32'h0, 1'b0, 1'b0, 32'hCC000004, 1'b1, 1'b0);
        checkOutput("ht_free1", 32'(vc_free1), 32'd0);
        checkOutput("ht_src1", 32'(src_addr_vc1), 32'h3);
        checkOutput("ht_flit1", flit_out_vc1, 32'hCC000004);
        checkOutput("ht_vc0_free", 32'(vc_free0), 32'd1);
        checkOutput("ht_vc0_valid", 32'(valid_vc0), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("ht_pop_free1", 32'(vc_free1), 32'd1);
        checkOutput("ht_pop_valid1", 32'(valid_vc1), 32'd0);
        checkOutput("ht_pop_vc0_free", 32'(vc_free0), 32'd1);

        $display("[TB] VC0 overflow");
        applyStimulus(32'h88000010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("ovf_src0", 32'(src_addr_vc0), 32'h2);
        applyStimulus(32'h08000011, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h08000012, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h08000013, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(32'h08000014, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_no_protocol", 32'(protocol_err), 32'd0);
        checkOutput("ovf_head0", flit_out_vc0, 32'h88000010);
        applyStimulus(32'h08000014, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("full_wr_rd_head", flit_out_vc0, 32'h08000011);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("drain_b2", flit_out_vc0, 32'h08000012);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("drain_b3", flit_out_vc0, 32'h08000013);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("drain_b4", flit_out_vc0, 32'h08000014);
        checkOutput("drain_b4_valid", 32'(valid_vc0), 32'd1);
        applyStimulus(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("drain_empty_valid", 32'(valid_vc0), 32'd0);
        checkOutput("drain_still_owned", 32'(vc_free0), 32'd0);

        $display("[TB] body to idle VC1");
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0C000002, 1'b1, 1'b0);
        checkOutput("perr_flag", 32'(protocol_err), 32'd1);
        checkOutput("perr_free1", 32'(vc_free1), 32'd1);
        checkOutput("perr_valid1", 32'(valid_vc1), 32'd0);
        checkOutput("perr_hold1", flit_out_vc1, 32'hCC000004);

        $display("[TB] reset mid-packet on VC0");
        applyStimulus(32'h08000020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid_valid0", 32'(valid_vc0), 32'd1);
        checkOutput("mid_flit0", flit_out_vc0, 32'h08000020);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid0", 32'(valid_vc0), 32'd0);
        checkOutput("mrst_free0", 32'(vc_free0), 32'd1);
        checkOutput("mrst_src0", 32'(src_addr_vc0), 32'h0);
        checkOutput("mrst_flit0", flit_out_vc0, 32'h0);
        checkOutput("mrst_overflow", 32'(overflow), 32'd0);
        checkOutput("mrst_protocol", 32'(protocol_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
